// File: rtl/imul_int_mul_nstage_pipe.sv
// Pipelined shift-and-add multiplier (low WIDTH bits of a*b), NSTAGES deep, one result per cycle with val/rdy back-pressure.
// Optional perf counters behind IMUL_INT_MUL_NSTAGE_PERF_EN; latency NSTAGES cycles, bubbles collapse under stall.
module imul_int_mul_nstage_pipe #(
   parameter int WIDTH   = 32,
   parameter int NSTAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_val,
   output logic             req_rdy,
   input  logic [WIDTH-1:0] req_msg_a,
   input  logic [WIDTH-1:0] req_msg_b,
   output logic             resp_val,
   input  logic             resp_rdy,
   output logic [WIDTH-1:0] resp_msg
`ifdef IMUL_INT_MUL_NSTAGE_PERF_EN
   ,
   output logic [31:0]      perf_xfers,
   output logic [31:0]      perf_stalls
`endif
);

   localparam int S = WIDTH / NSTAGES;

   if (WIDTH < 2 || NSTAGES < 1 || NSTAGES > WIDTH || (WIDTH % NSTAGES) != 0) begin : g_param_check
      $error("imul_int_mul_nstage_pipe: illegal WIDTH/NSTAGES combination");
   end

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] r;
   } lane_t;

   function automatic lane_t steps(input lane_t in);
      lane_t x;
      x = in;
      for (int i = 0; i < S; i++) begin
         x.r = x.r + (x.b[0] ? x.a : '0);
         x.a = x.a << 1;
         x.b = x.b >> 1;
      end
      return x;
   endfunction

   logic [NSTAGES-1:0] val_q, val_d, go;
   lane_t              lane_q [NSTAGES];
   lane_t              lane_d [NSTAGES];
   lane_t              lane_in0;

   // A stage may advance if it is empty or any stage downstream of it has a hole (or the sink is ready).
   always_comb begin
      go = '0;
      for (int k = 0; k < NSTAGES; k++) begin
         go[k] = resp_rdy;
         for (int j = k; j < NSTAGES; j++) begin
            if (!val_q[j]) go[k] = 1'b1;
         end
      end
   end

   always_comb begin
      lane_in0.a = req_msg_a;
      lane_in0.b = req_msg_b;
      lane_in0.r = '0;
      val_d[0]   = go[0] ? (req_val && go[0]) : val_q[0];
      lane_d[0]  = go[0] ? steps(lane_in0) : lane_q[0];
      for (int k = 1; k < NSTAGES; k++) begin
         val_d[k]  = go[k] ? val_q[k-1] : val_q[k];
         lane_d[k] = go[k] ? steps(lane_q[k-1]) : lane_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) val_q <= '0;
      else        val_q <= val_d;
   end

   // Datapath is deliberately unreset; only the valid bits define occupancy.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NSTAGES; k++) lane_q[k] <= lane_d[k];
   end

   assign req_rdy  = go[0];
   assign resp_val = val_q[NSTAGES-1];
   assign resp_msg = lane_q[NSTAGES-1].r;

   logic unused_tail_bits;
   assign unused_tail_bits = ^{lane_q[NSTAGES-1].a, lane_q[NSTAGES-1].b};

`ifdef IMUL_INT_MUL_NSTAGE_PERF_EN
   logic [31:0] xfers_q, xfers_d, stalls_q, stalls_d;

   always_comb begin
      xfers_d  = xfers_q  + ((req_val && req_rdy)    ? 32'd1 : 32'd0);
      stalls_d = stalls_q + ((resp_val && !resp_rdy) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         xfers_q  <= '0;
         stalls_q <= '0;
      end else begin
         xfers_q  <= xfers_d;
         stalls_q <= stalls_d;
      end
   end

   assign perf_xfers  = xfers_q;
   assign perf_stalls = stalls_q;
`endif

endmodule
